// File: rtl/sc_pkg.sv
// Shared definitions for the scan-chain loader: FSM state encoding and a
// ceiling-log2 helper used to size counters.
package sc_pkg;

  typedef logic [1:0] sc_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLR   = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_word_shifter.sv
// Word holding register for the loader: captures one input word, then hands
// it out LSB first while tracking how many bits are still pending.
module sc_word_shifter
  import sc_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic              i_clk,
  input  logic              i_clear,
  input  logic              i_flush,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_din,
  input  logic              i_shift,
  output logic              o_bit0,
  output logic              o_empty
);

  localparam int PEND_W = clog2(WORD_W + 1);

  logic [WORD_W-1:0] r_sr;
  logic [PEND_W-1:0] r_pend;

  // Load and shift never coincide: load needs an empty register, shift a non-empty one.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_sr   <= '0;
      r_pend <= '0;
    end else if (i_flush) begin
      r_sr   <= '0;
      r_pend <= '0;
    end else if (i_load) begin
      r_sr   <= i_din;
      r_pend <= PEND_W'(WORD_W);
    end else if (i_shift) begin
      r_sr   <= r_sr >> 1;
      r_pend <= r_pend - PEND_W'(1);
    end
  end

  assign o_bit0  = r_sr[0];
  assign o_empty = (r_pend == '0);

endmodule

// File: rtl/sc_loader.sv
// Scan-chain loader: clears the downstream chain, then streams SC_LENGTH bits
// from incoming words (bit 0 first) with a registered shift enable.
module sc_loader
  import sc_pkg::*;
#(
  parameter  int SC_LENGTH = 5,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = clog2(SC_LENGTH + 1)
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              sc_en,
  output logic              sc_data,
  output logic              sc_clear_n,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic [1:0]        dbg_state
);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_sc_en;
  logic             r_sc_data;
  logic             w_empty;
  logic             w_bit0;
  logic             w_room;
  logic             w_ready;
  logic             w_load;
  logic             w_shift;
  logic             w_last;
  logic             w_flush;

  // Handshake: a word moves only in a cycle where din_valid and din_ready are
  // both 1; din_ready depends on registered state only, never on din_valid.
  assign w_room  = (r_bit_count < CNT_W'(SC_LENGTH));
  assign w_ready = (r_state == ST_SHIFT) && w_empty && w_room;
  assign w_load  = din_valid && w_ready;
  assign w_shift = (r_state == ST_SHIFT) && !w_empty && w_room;
  assign w_last  = w_shift && (r_bit_count == CNT_W'(SC_LENGTH - 1));
  // Leftover bits of the final word are dropped on the way through DONE.
  assign w_flush = (r_state == ST_CLR) || (r_state == ST_DONE);

  sc_word_shifter #(
    .WORD_W(WORD_W)
  ) u_shifter (
    .i_clk   (clk),
    .i_clear (clear),
    .i_flush (w_flush),
    .i_load  (w_load),
    .i_din   (din),
    .i_shift (w_shift),
    .o_bit0  (w_bit0),
    .o_empty (w_empty)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_CLR;
      ST_CLR:   w_next = ST_SHIFT;
      ST_SHIFT: if (w_last) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state     <= ST_IDLE;
      r_bit_count <= '0;
      r_sc_en     <= 1'b0;
      r_sc_data   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sc_en <= w_shift;
      if (w_shift) r_sc_data <= w_bit0;
      if (r_state == ST_CLR) begin
        r_bit_count <= '0;
      end else if (w_shift) begin
        r_bit_count <= r_bit_count + CNT_W'(1);
      end
    end
  end

  assign din_ready  = w_ready;
  assign sc_en      = r_sc_en;
  assign sc_data    = r_sc_data;
  assign sc_clear_n = (r_state != ST_CLR);
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign bit_count  = r_bit_count;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_sc_loader.sv
// Bench for sc_loader: two instances (5-bit and 12-bit chains, 8-bit words)
// with a scan-chain model, an expected-bit scoreboard and random sequences.
module tb_sc_loader;

  logic       clk = 1'b0;
  logic       clear;
  logic [1:0] start, din_valid, din_ready, sc_en, sc_data, sc_clear_n, busy, done;
  logic [7:0] din [2];
  logic [2:0] bc0;
  logic [3:0] bc1;
  logic [1:0] st0, st1;
  logic [1:0] preload;
  logic [11:0] chain [2];

  logic exp_q0[$];
  logic exp_q1[$];

  int n_cmp = 0;
  int n_err = 0;
  int pulses [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int clr_cnt [2] = '{0, 0};

  always #5 clk = ~clk;

  sc_loader #(.SC_LENGTH(5), .WORD_W(8)) dut0 (
    .clk(clk), .clear(clear), .start(start[0]), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .sc_en(sc_en[0]), .sc_data(sc_data[0]), .sc_clear_n(sc_clear_n[0]),
    .busy(busy[0]), .done(done[0]), .bit_count(bc0), .dbg_state(st0)
  );

  sc_loader #(.SC_LENGTH(12), .WORD_W(8)) dut1 (
    .clk(clk), .clear(clear), .start(start[1]), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .sc_en(sc_en[1]), .sc_data(sc_data[1]), .sc_clear_n(sc_clear_n[1]),
    .busy(busy[1]), .done(done[1]), .bit_count(bc1), .dbg_state(st1)
  );

  function automatic int len(input int d);
    return (d == 0) ? 5 : 12;
  endfunction

  function automatic int get_bc(input int d);
    return (d == 0) ? int'(bc0) : int'(bc1);
  endfunction

  function automatic logic [11:0] shift_in(input int d, input logic [11:0] c, input logic b);
    logic [11:0] r;
    r = c >> 1;
    r[len(d)-1] = b;
    return r;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic pop_exp(input int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  task automatic push_exp(input int d, input logic b);
    if (d == 0) exp_q0.push_back(b);
    else exp_q1.push_back(b);
  endtask

  task automatic flush_exp(input int d);
    if (d == 0) exp_q0.delete();
    else exp_q1.delete();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream scan chain: bit enters at the top, moves toward position 0.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (preload[d]) chain[d] <= (d == 0) ? 12'h01F : 12'hFFF;
      else if (!sc_clear_n[d]) chain[d] <= '0;
      else if (sc_en[d]) chain[d] <= shift_in(d, chain[d], sc_data[d]);
    end
  end

  // Monitor: every shift pulse must carry the next expected stream bit.
  always @(negedge clk) begin
    if (!clear) begin
      for (int d = 0; d < 2; d++) begin
        if (sc_en[d]) begin
          pulses[d]++;
          if (q_size(d) == 0) check("sc_en_unexpected", 32'd1, 32'd0);
          else check("sc_data", 32'(sc_data[d]), 32'(pop_exp(d)));
        end
        if (done[d]) done_cnt[d]++;
        if (!sc_clear_n[d]) clr_cnt[d]++;
      end
    end
  end

  // Caller is at posedge+1. Runs one load sequence on instance d.
  task automatic run_seq(input int d, input bit fixed, input logic [7:0] f0, input logic [7:0] f1,
                         input int gap_pct, input bit gap3, input bit inject, input int abort_at);
    logic [7:0]  wq[$];
    logic [7:0]  w;
    logic [11:0] exp_chain;
    int L, nw, idx, pushed, cyc, p0, d0, c0, bc_done, bc_inj, done_idx, bcg;
    bit got_done, gap_done, inj_armed, inj_chk;
    L = len(d);
    nw = (L + 7) / 8;
    if (fixed) begin
      wq.push_back(f0);
      wq.push_back(f1);
    end
    while (wq.size() < nw + 1) wq.push_back(8'($urandom_range(0, 255)));
    exp_chain = '0;
    for (int i = 0; i < L; i++) begin
      w = wq[i / 8];
      exp_chain[i] = w[i % 8];
    end
    p0 = pulses[d]; d0 = done_cnt[d]; c0 = clr_cnt[d];
    preload[d] = 1'b1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    preload[d] = 1'b0;
    start[d] = 1'b0;
    check("clr_low", 32'(sc_clear_n[d]), 32'd0);
    check("busy_clr", 32'(busy[d]), 32'd1);
    idx = 0; pushed = 0; cyc = 0; got_done = 0; gap_done = 0;
    inj_armed = inject; bc_done = 0; done_idx = 0; bc_inj = 0;
    while (!got_done && cyc < 400) begin
      if (cyc == 1) begin
        check("clr_one_cycle", 32'(sc_clear_n[d]), 32'd1);
        check("chain_cleared", 32'(chain[d]), 32'd0);
      end
      if (abort_at > 0 && get_bc(d) == abort_at) begin
        #2 clear = 1'b1;
        #1;
        check("abort_sc_en", 32'(sc_en[d]), 32'd0);
        check("abort_sc_data", 32'(sc_data[d]), 32'd0);
        check("abort_clear_n", 32'(sc_clear_n[d]), 32'd1);
        check("abort_ready", 32'(din_ready[d]), 32'd0);
        check("abort_busy", 32'(busy[d]), 32'd0);
        check("abort_done", 32'(done[d]), 32'd0);
        check("abort_bc", 32'(get_bc(d)), 32'd0);
        flush_exp(d);
        p0 = pulses[d];
        repeat (2) @(posedge clk);
        #1 clear = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_en", 32'(pulses[d] - p0), 32'd0);
        check("abort_idle", 32'(busy[d]), 32'd0);
        din_valid[d] = 1'b0;
        return;
      end
      if (gap3 && !gap_done && idx == 1 && din_ready[d]) begin
        din_valid[d] = 1'b0;
        bcg = get_bc(d);
        for (int g = 0; g < 3; g++) begin
          @(negedge clk);
          check("gap_bc_hold", 32'(get_bc(d)), 32'(bcg));
          if (g > 0) check("gap_sc_en", 32'(sc_en[d]), 32'd0);
          @(posedge clk); #1;
        end
        cyc += 3;
        gap_done = 1;
        continue;
      end
      din_valid[d] = (idx < wq.size()) && ($urandom_range(1, 100) > gap_pct);
      din[d] = (idx < wq.size()) ? wq[idx] : 8'h00;
      inj_chk = 0;
      if (inj_armed && cyc >= 3 && get_bc(d) > 0 && !done[d]) begin
        start[d] = 1'b1;
        bc_inj = get_bc(d);
        inj_armed = 0;
        inj_chk = 1;
      end
      @(negedge clk);
      if (din_valid[d] && din_ready[d] && idx < wq.size()) begin
        w = wq[idx];
        for (int b = 0; b < 8; b++) begin
          if (pushed < L) begin
            push_exp(d, w[b]);
            pushed++;
          end
        end
        idx++;
      end
      if (done[d]) begin
        got_done = 1;
        bc_done = get_bc(d);
        done_idx = cyc;
        if (inject) start[d] = 1'b1;
      end
      @(posedge clk); #1;
      start[d] = 1'b0;
      if (inj_chk)
        check("inj_shift_bc", 32'(get_bc(d) == bc_inj || get_bc(d) == bc_inj + 1), 32'd1);
      cyc++;
    end
    din_valid[d] = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    check("bc_at_done", 32'(bc_done), 32'(L));
    if (gap_pct == 0 && !gap3) check("seq_len", 32'(done_idx), 32'(1 + nw + L));
    check("done_pulse_end", 32'(done[d]), 32'd0);
    check("busy_idle", 32'(busy[d]), 32'd0);
    check("ready_idle", 32'(din_ready[d]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("chain", 32'(chain[d]), 32'(exp_chain));
    check("bc_hold", 32'(get_bc(d)), 32'(L));
    check("sc_en_pulses", 32'(pulses[d] - p0), 32'(L));
    check("done_cycles", 32'(done_cnt[d] - d0), 32'd1);
    check("clr_cycles", 32'(clr_cnt[d] - c0), 32'd1);
    check("words_taken", 32'(idx), 32'(nw));
    check("exp_q_empty", 32'(q_size(d)), 32'd0);
    flush_exp(d);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    start = '0;
    din_valid = '0;
    din[0] = '0;
    din[1] = '0;
    preload = '0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check("rst_sc_en", 32'(sc_en[d]), 32'd0);
      check("rst_sc_data", 32'(sc_data[d]), 32'd0);
      check("rst_clear_n", 32'(sc_clear_n[d]), 32'd1);
      check("rst_ready", 32'(din_ready[d]), 32'd0);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_done", 32'(done[d]), 32'd0);
      check("rst_bc", 32'(get_bc(d)), 32'd0);
    end
    @(posedge clk); #1;
    clear = 1'b0;

    run_seq(0, 1'b1, 8'h16, 8'h00, 0, 1'b0, 1'b0, 0);
    check("chain_0x16", 32'(chain[0]), 32'h016);
    run_seq(1, 1'b1, 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 0);
    check("chain_ca5", 32'(chain[1]), 32'hCA5);
    run_seq(1, 1'b1, 8'hA5, 8'h3C, 0, 1'b1, 1'b0, 0);
    check("chain_ca5_gap", 32'(chain[1]), 32'hCA5);
    run_seq(0, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b1, 0);
    run_seq(1, 1'b0, 8'h00, 8'h00, 20, 1'b0, 1'b1, 0);
    run_seq(1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 2);
    run_seq(1, 1'b0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      run_seq(int'($urandom_range(0, 1)), 1'b0, 8'h00, 8'h00, int'($urandom_range(0, 60)),
              1'b0, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
